// File: rtl/pipe_stage_chain_if.sv
// Handshake and payload bundle for pipe_stage_chain: the producer/stage-logic side
// uses the master modport, the register chain uses the slave modport.
interface pipe_stage_chain_if #(
    parameter int NUM_STAGES = 4,
    parameter int BUS_W      = 256,
    parameter int CNT_W      = 32
);
    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic                            in_valid;
    logic                            in_ready_go;
    logic [BUS_W-1:0]                in_bus;
    logic                            in_allow_in;
    logic [NUM_STAGES-1:0]           stage_ready_go;
    logic [NUM_STAGES-2:0]           stage_valid_nxt;
    logic [(NUM_STAGES-1)*BUS_W-1:0] stage_bus_nxt;
    logic                            sink_ready;
    logic [NUM_STAGES-1:0]           flush_vec;
    logic [NUM_STAGES-1:0]           reg_valid;
    logic [NUM_STAGES*BUS_W-1:0]     reg_bus;
    logic                            out_fire;
    logic [OCC_W-1:0]                occupancy;
    logic [NUM_STAGES*CNT_W-1:0]     stall_cnt;

    modport master (
        output in_valid, in_ready_go, in_bus, stage_ready_go, stage_valid_nxt,
               stage_bus_nxt, sink_ready, flush_vec,
        input  in_allow_in, reg_valid, reg_bus, out_fire, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_ready_go, in_bus, stage_ready_go, stage_valid_nxt,
               stage_bus_nxt, sink_ready, flush_vec,
        output in_allow_in, reg_valid, reg_bus, out_fire, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Pipeline-register chain with valid/allow_in/ready_go handshake and per-register flush.
// Define PIPE_STALL_CNT_EN to build the saturating per-register stall counters.
module pipe_stage_chain #(
    parameter int NUM_STAGES = 4,
    parameter int BUS_W      = 256,
    parameter int CNT_W      = 32
) (
    input logic                 clk,
    input logic                 reset,
    pipe_stage_chain_if.slave   pipe
);
    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES:0]         allow_in;
    logic [NUM_STAGES-1:0]       fire;
    logic                        in_fire;
    logic [NUM_STAGES-1:0]       valid_vec;
    logic [NUM_STAGES*BUS_W-1:0] bus_vec;
    logic [NUM_STAGES*CNT_W-1:0] cnt_vec;
    logic [OCC_W-1:0]            occ_next;

    // Back-pressure ripples from the sink toward register 0 in one combinational pass.
    always_comb begin
        allow_in             = '0;
        fire                 = '0;
        allow_in[NUM_STAGES] = pipe.sink_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            allow_in[k] = ~valid_vec[k] | (pipe.stage_ready_go[k] & allow_in[k+1]);
            fire[k]     = valid_vec[k] & pipe.stage_ready_go[k] & allow_in[k+1];
        end
    end

    assign in_fire = pipe.in_valid & pipe.in_ready_go & allow_in[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_reg
            logic             cap_fire;
            logic             cap_valid;
            logic [BUS_W-1:0] cap_bus;
            logic             valid_reg;
            logic [BUS_W-1:0] bus_reg;

            if (gi == 0) begin : g_head
                assign cap_fire  = in_fire;
                assign cap_valid = in_fire;
                assign cap_bus   = pipe.in_bus;
            end else begin : g_body
                assign cap_fire  = fire[gi-1];
                assign cap_valid = fire[gi-1] & pipe.stage_valid_nxt[gi-1];
                assign cap_bus   = pipe.stage_bus_nxt[(gi-1)*BUS_W +: BUS_W];
            end

            // Flush wins over everything, including a blocked downstream.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    bus_reg   <= '0;
                end else if (pipe.flush_vec[gi]) begin
                    valid_reg <= 1'b0;
                    bus_reg   <= '0;
                end else if (allow_in[gi]) begin
                    valid_reg <= cap_valid;
                    if (cap_fire) begin
                        bus_reg <= cap_bus;
                    end
                end
            end

            assign valid_vec[gi]                 = valid_reg;
            assign bus_vec[gi*BUS_W +: BUS_W]    = bus_reg;

`ifdef PIPE_STALL_CNT_EN
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (valid_reg & ~fire[gi] & ~pipe.flush_vec[gi] & ~(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_vec[gi*CNT_W +: CNT_W] = cnt_reg;
`else
            assign cnt_vec[gi*CNT_W +: CNT_W] = {CNT_W{1'b0}};
`endif
        end
    endgenerate

    always_comb begin
        occ_next = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occ_next = occ_next + OCC_W'(valid_vec[k]);
        end
    end

    assign pipe.in_allow_in = allow_in[0];
    assign pipe.out_fire    = fire[NUM_STAGES-1];
    assign pipe.reg_valid   = valid_vec;
    assign pipe.reg_bus     = bus_vec;
    assign pipe.occupancy   = occ_next;
    assign pipe.stall_cnt   = cnt_vec;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (4 registers, 8-bit payload); stage logic is a
// pass-through so each register receives its predecessor's payload unchanged.
module tb_pipe_stage_chain;
    localparam int NS = 4;
    localparam int BW = 8;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_stage_chain_if #(.NUM_STAGES(NS), .BUS_W(BW), .CNT_W(CW)) pif ();

    pipe_stage_chain #(.NUM_STAGES(NS), .BUS_W(BW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (pif.slave)
    );

    assign pif.stage_bus_nxt = pif.reg_bus[(NS-1)*BW-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-12s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [3:0] v, input logic [31:0] b);
        check_val({tag, "_v"}, pif.reg_valid, v);
        check_val({tag, "_b"}, pif.reg_bus, b);
    endtask

    initial begin
        reset               = 1'b1;
        pif.in_valid        = 1'b0;
        pif.in_ready_go     = 1'b1;
        pif.in_bus          = '0;
        pif.stage_ready_go  = 4'hF;
        pif.stage_valid_nxt = 3'b111;
        pif.sink_ready      = 1'b1;
        pif.flush_vec       = 4'h0;
        repeat (2) tick();

        check_val("rst_valid", pif.reg_valid, 4'h0);
        check_val("rst_allow", pif.in_allow_in, 1'b1);
        check_val("rst_ofire", pif.out_fire, 1'b0);
        check_val("rst_occ", pif.occupancy, 3'd0);
        check_val("rst_cnt", pif.stall_cnt, 16'h0);
        reset = 1'b0;

        // Fill the pipe with 0x01..0x04
        for (int i = 1; i <= 4; i++) begin
            pif.in_valid = 1'b1;
            pif.in_bus   = 8'(i);
            #1;
            check_val("fill_allow", pif.in_allow_in, 1'b1);
            tick();
        end
        check_regs("full", 4'hF, 32'h01020304);
        check_val("full_occ", pif.occupancy, 3'd4);
        check_val("full_ofire", pif.out_fire, 1'b1);

        // Sink back-pressure for 3 cycles
        pif.sink_ready = 1'b0;
        pif.in_bus     = 8'h05;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_val("bp_allow", pif.in_allow_in, 1'b0);
            check_val("bp_ofire", pif.out_fire, 1'b0);
            tick();
            check_regs("bp_hold", 4'hF, 32'h01020304);
        end

        pif.sink_ready = 1'b1;
        for (int i = 5; i <= 6; i++) begin
            pif.in_bus = 8'(i);
            #1;
            check_val("rel_ofire", pif.out_fire, 1'b1);
            check_val("rel_allow", pif.in_allow_in, 1'b1);
            tick();
            check_regs("rel", 4'hF, {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)});
        end

        // Stage 1 not ready for 2 cycles: bubbles behind reg1
        pif.stage_ready_go = 4'b1101;
        pif.in_bus         = 8'h07;
        #1;
        check_val("bub1_allow", pif.in_allow_in, 1'b0);
        tick();
        check_regs("bub1", 4'b1011, 32'h04040506);
        #1;
        check_val("bub2_allow", pif.in_allow_in, 1'b0);
        tick();
        check_regs("bub2", 4'b0011, 32'h04040506);
        check_val("bub2_occ", pif.occupancy, 3'd2);
        pif.stage_ready_go = 4'hF;
        #1;
        check_val("bub3_allow", pif.in_allow_in, 1'b1);
        tick();
        check_regs("bub3", 4'b0111, 32'h04050607);
        pif.in_bus = 8'h08;
        tick();
        check_regs("bub4", 4'hF, 32'h05060708);

        // Flush regs 0..2 while reg2 fires into reg3
        pif.flush_vec = 4'b0111;
        pif.in_bus    = 8'h09;
        tick();
        check_regs("fl1", 4'b1000, 32'h06000000);
        pif.flush_vec = 4'h0;
        for (int i = 10; i <= 13; i++) begin
            pif.in_bus = 8'(i);
            tick();
        end
        check_regs("refill", 4'hF, 32'h0A0B0C0D);

        // Same flush but stage 3 kills its payload
        pif.flush_vec       = 4'b0111;
        pif.stage_valid_nxt = 3'b011;
        pif.in_bus          = 8'h0E;
        tick();
        check_regs("fl2", 4'b0000, 32'h0B000000);
        check_val("fl2_occ", pif.occupancy, 3'd0);
        pif.flush_vec       = 4'h0;
        pif.stage_valid_nxt = 3'b111;

        // Flush of a blocked register
        for (int i = 8'h21; i <= 8'h24; i++) begin
            pif.in_bus = 8'(i);
            tick();
        end
        check_regs("fill3", 4'hF, 32'h21222324);
        pif.sink_ready = 1'b0;
        pif.in_valid   = 1'b0;
        pif.flush_vec  = 4'b1000;
        #1;
        check_val("fl3_allow", pif.in_allow_in, 1'b0);
        tick();
        check_regs("fl3", 4'b0111, 32'h00222324);
        pif.flush_vec = 4'h0;
        tick();
        check_regs("fl3_adv", 4'b1110, 32'h22232424);

        // Long sink stall on reg3
        repeat (20) tick();
        check_regs("stall20", 4'b1110, 32'h22232424);
`ifdef PIPE_STALL_CNT_EN
        check_val("cnt3_sat", pif.stall_cnt[15:12], 4'hF);
`else
        check_val("cnt_zero", pif.stall_cnt, 16'h0);
`endif

        // Mid-cycle asynchronous reset with a full pipe
        pif.in_valid = 1'b1;
        pif.in_bus   = 8'h30;
        tick();
        check_regs("full2", 4'hF, 32'h22232430);
        #2;
        reset = 1'b1;
        #1;
        check_regs("arst", 4'h0, 32'h0);
        check_val("arst_allow", pif.in_allow_in, 1'b1);
        check_val("arst_occ", pif.occupancy, 3'd0);
        check_val("arst_ofire", pif.out_fire, 1'b0);
        check_val("arst_cnt", pif.stall_cnt, 16'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
